// File: rtl/l2axi_pkg.sv
// rtl/l2axi_pkg.sv - shared AXI constants, FSM encodings and burst helpers for the L2-to-AXI bridge
package l2axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // Width of one cache line in bits.
  function automatic int line_bits(input int offset_width);
    return 32 << offset_width;
  endfunction

  // AXLEN: a whole line for cached accesses, a single beat for strongly-ordered ones.
  function automatic logic [7:0] burst_len(input int offset_width, input logic suc);
    return suc ? 8'd0 : 8'((1 << offset_width) - 1);
  endfunction

  // AXADDR: cached bursts start at the line base, strongly-ordered beats keep the full address.
  function automatic logic [31:0] burst_addr(input int offset_width, input logic suc,
                                             input logic [31:0] addr);
    logic [31:0] mask;
    mask = ~((32'd1 << (offset_width + 2)) - 32'd1);
    return suc ? addr : (addr & mask);
  endfunction

endpackage

// File: rtl/l2axi_wbuf.sv
// rtl/l2axi_wbuf.sv - one-line write buffer and W-beat sequencer
module l2axi_wbuf import l2axi_pkg::*; #(
  parameter int offset_width = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               capture,
  input  logic                               suc_in,
  input  logic [31:0]                        addr_in,
  input  logic [line_bits(offset_width)-1:0] line_in,
  input  logic [3:0]                         strb_in,
  input  logic                               beat_adv,
  output logic [31:0]                        addr,
  output logic                               suc,
  output logic [31:0]                        wdata,
  output logic [3:0]                         wstrb,
  output logic                               wlast
);

  localparam int LW = line_bits(offset_width);

  logic [LW-1:0]           line_q, line_d;
  logic [offset_width-1:0] beat_q, beat_d;
  logic [31:0]             addr_q, addr_d;
  logic                    suc_q, suc_d;
  logic [3:0]              strb_q, strb_d;

  // Load a fresh line on capture; otherwise shift the next word into place per accepted beat.
  always_comb begin
    line_d = line_q;
    beat_d = beat_q;
    addr_d = addr_q;
    suc_d  = suc_q;
    strb_d = strb_q;
    if (capture) begin
      line_d = line_in;
      beat_d = '0;
      addr_d = addr_in;
      suc_d  = suc_in;
      strb_d = strb_in;
    end else if (beat_adv) begin
      line_d = line_q >> 32;
      beat_d = beat_q + 1'b1;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      line_q <= '0;
      beat_q <= '0;
      addr_q <= '0;
      suc_q  <= 1'b0;
      strb_q <= 4'h0;
    end else begin
      line_q <= line_d;
      beat_q <= beat_d;
      addr_q <= addr_d;
      suc_q  <= suc_d;
      strb_q <= strb_d;
    end
  end

  assign addr  = addr_q;
  assign suc   = suc_q;
  assign wdata = line_q[31:0];
  assign wstrb = suc_q ? strb_q : 4'hF;
  assign wlast = suc_q | (&beat_q);

endmodule

// File: rtl/l2cache_axi_bridge.sv
// rtl/l2cache_axi_bridge.sv - L2 line requests to AXI4 bursts; L2AXI_RAW_BYPASS_EN relaxes read-after-write ordering to a line match
module l2cache_axi_bridge import l2axi_pkg::*; #(
  parameter int         offset_width = 2,
  parameter logic [3:0] AXI_ID       = 4'd1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               l2cache_mem_req_r,
  input  logic                               l2cache_mem_req_w,
  input  logic                               l2cache_mem_rdy,
  input  logic                               l2cache_mem_SUC,
  input  logic [31:0]                        l2cache_mem_addr_r,
  input  logic [31:0]                        l2cache_mem_addr_w,
  input  logic [line_bits(offset_width)-1:0] l2cache_mem_wdata,
  input  logic [3:0]                         l2cache_mem_wstrb,
  output logic                               mem_l2cache_addrOK_r,
  output logic                               mem_l2cache_addrOK_w,
  output logic                               mem_l2cache_dataOK,
  output logic [line_bits(offset_width)-1:0] mem_l2cache_rdata,
  output logic [3:0]                         arid,
  output logic [31:0]                        araddr,
  output logic [7:0]                         arlen,
  output logic [2:0]                         arsize,
  output logic [1:0]                         arburst,
  output logic                               arvalid,
  input  logic                               arready,
  input  logic [31:0]                        rdata,
  input  logic                               rlast,
  input  logic                               rvalid,
  output logic                               rready,
  output logic [3:0]                         awid,
  output logic [31:0]                        awaddr,
  output logic [7:0]                         awlen,
  output logic [2:0]                         awsize,
  output logic [1:0]                         awburst,
  output logic                               awvalid,
  input  logic                               awready,
  output logic [31:0]                        wdata,
  output logic [3:0]                         wstrb,
  output logic                               wlast,
  output logic                               wvalid,
  input  logic                               wready,
  input  logic                               bvalid,
  output logic                               bready
);

  localparam int LW = line_bits(offset_width);

  rd_state_e               rd_state_q, rd_state_d;
  logic [31:0]             rd_addr_q, rd_addr_d;
  logic                    rd_suc_q, rd_suc_d;
  logic [offset_width-1:0] rd_beat_q, rd_beat_d;
  logic                    rd_first_q, rd_first_d;
  logic [LW-1:0]           rdata_q, rdata_d;
  logic                    dataok_q, dataok_d;
  logic [31:0]             rd_base;
  logic                    rd_allowed;

  wr_state_e               wr_state_q, wr_state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    wb_capture;
  logic [31:0]             wb_addr;
  logic                    wb_suc;

  // Decide whether a pending read may leave idle without overtaking a buffered write-back.
  always_comb begin
`ifdef L2AXI_RAW_BYPASS_EN
    rd_allowed = !((wr_state_q != W_IDLE) &&
                   (wb_addr[31:offset_width+2] == l2cache_mem_addr_r[31:offset_width+2])) &&
                 !(l2cache_mem_req_w && (wr_state_q == W_IDLE) &&
                   (l2cache_mem_addr_w[31:offset_width+2] == l2cache_mem_addr_r[31:offset_width+2]));
`else
    rd_allowed = (wr_state_q == W_IDLE) && !l2cache_mem_req_w;
`endif
  end

  // Read FSM: issue AR, assemble the returned beats into the line, then hand it to the L2.
  always_comb begin
    rd_state_d           = rd_state_q;
    rd_addr_d            = rd_addr_q;
    rd_suc_d             = rd_suc_q;
    rd_beat_d            = rd_beat_q;
    rd_first_d           = rd_first_q;
    rdata_d              = rdata_q;
    dataok_d             = 1'b0;
    arvalid              = 1'b0;
    rready               = 1'b0;
    mem_l2cache_addrOK_r = 1'b0;
    rd_base              = 32'(rd_beat_q) << 5;
    case (rd_state_q)
      R_IDLE: begin
        // dataok_q still high means the L2 has not yet seen the previous line and may still hold req_r.
        if (l2cache_mem_req_r && rd_allowed && !dataok_q) begin
          rd_addr_d  = burst_addr(offset_width, l2cache_mem_SUC, l2cache_mem_addr_r);
          rd_suc_d   = l2cache_mem_SUC;
          rd_state_d = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          mem_l2cache_addrOK_r = 1'b1;
          rd_beat_d            = '0;
          rd_first_d           = 1'b1;
          rd_state_d           = R_DATA;
        end
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          // The previous line stays visible until the first beat of the next one lands.
          if (rd_first_q) rdata_d = '0;
          rdata_d[rd_base +: 32] = rdata;
          rd_beat_d  = rd_beat_q + 1'b1;
          rd_first_d = 1'b0;
          if (rlast) rd_state_d = R_DONE;
        end
      end
      R_DONE: begin
        if (l2cache_mem_rdy) begin
          dataok_d   = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM: capture into the buffer, drain AW and W independently, then wait for B.
  always_comb begin
    wr_state_d           = wr_state_q;
    aw_done_d            = aw_done_q;
    w_done_d             = w_done_q;
    wb_capture           = 1'b0;
    mem_l2cache_addrOK_w = 1'b0;
    awvalid              = 1'b0;
    wvalid               = 1'b0;
    bready               = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (l2cache_mem_req_w) begin
          wb_capture           = 1'b1;
          mem_l2cache_addrOK_w = 1'b1;
          aw_done_d            = 1'b0;
          w_done_d             = 1'b0;
          wr_state_d           = W_XFER;
        end
      end
      W_XFER: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready && wlast) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // State registers for both FSMs and the read line.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_suc_q   <= 1'b0;
      rd_beat_q  <= '0;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
      dataok_q   <= 1'b0;
      wr_state_q <= W_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_suc_q   <= rd_suc_d;
      rd_beat_q  <= rd_beat_d;
      rd_first_q <= rd_first_d;
      rdata_q    <= rdata_d;
      dataok_q   <= dataok_d;
      wr_state_q <= wr_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  l2axi_wbuf #(.offset_width(offset_width)) u_wbuf (
    .clk      (clk),
    .rstn     (rstn),
    .capture  (wb_capture),
    .suc_in   (l2cache_mem_SUC),
    .addr_in  (l2cache_mem_addr_w),
    .line_in  (l2cache_mem_wdata),
    .strb_in  (l2cache_mem_wstrb),
    .beat_adv (wvalid && wready),
    .addr     (wb_addr),
    .suc      (wb_suc),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast)
  );

  assign mem_l2cache_dataOK = dataok_q;
  assign mem_l2cache_rdata  = rdata_q;

  assign arid    = AXI_ID;
  assign araddr  = rd_addr_q;
  assign arlen   = burst_len(offset_width, rd_suc_q);
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;

  assign awid    = AXI_ID;
  assign awaddr  = burst_addr(offset_width, wb_suc, wb_addr);
  assign awlen   = burst_len(offset_width, wb_suc);
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_l2cache_axi_bridge.sv
// tb/tb_l2cache_axi_bridge.sv - directed self-checking bench for l2cache_axi_bridge
module tb_l2cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_r, req_w, rdy, suc;
  logic [31:0]  addr_r, addr_w;
  logic [127:0] l2_wdata;
  logic [3:0]   l2_wstrb;
  logic         addrok_r, addrok_w, dataok;
  logic [127:0] l2_rdata;
  logic [3:0]   arid, awid;
  logic [31:0]  araddr, awaddr;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [31:0]  rdata, wdata;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2cache_axi_bridge dut (
    .clk(clk), .rstn(rstn),
    .l2cache_mem_req_r(req_r), .l2cache_mem_req_w(req_w), .l2cache_mem_rdy(rdy),
    .l2cache_mem_SUC(suc), .l2cache_mem_addr_r(addr_r), .l2cache_mem_addr_w(addr_w),
    .l2cache_mem_wdata(l2_wdata), .l2cache_mem_wstrb(l2_wstrb),
    .mem_l2cache_addrOK_r(addrok_r), .mem_l2cache_addrOK_w(addrok_w),
    .mem_l2cache_dataOK(dataok), .mem_l2cache_rdata(l2_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Deliver n R beats starting at value d0, rlast on the final one.
  task automatic rd_beats(input logic [31:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rdata  = d0 + 32'(i);
      rlast  = (i == n - 1);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; req_r = 0; req_w = 0; rdy = 1; suc = 0;
    addr_r = 0; addr_w = 0; l2_wdata = 0; l2_wstrb = 0;
    arready = 0; rdata = 0; rlast = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    tick(); tick();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_dataok", dataok, 0);
    chk("rst_rdata", l2_rdata, 0);
    rstn = 1'b1;
    tick();

    // 1: cached read, arready two cycles late
    req_r = 1; addr_r = 32'h1000_0014;
    #1 chk("t1_idle_arvalid", arvalid, 0);
    tick();
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1000_0010);
    chk("t1_arlen", arlen, 3);
    chk("t1_arsize", arsize, 3'b010);
    chk("t1_arburst", arburst, 2'b01);
    chk("t1_arid", arid, 1);
    tick(); tick();
    chk("t1_addrok_wait", addrok_r, 0);
    arready = 1;
    #1 chk("t1_addrok", addrok_r, 1);
    tick();
    arready = 0; req_r = 0;
    chk("t1_addrok_pulse", addrok_r, 0);
    chk("t1_rready", rready, 1);
    rd_beats(32'hA0, 4);
    chk("t1_dataok_early", dataok, 0);
    chk("t1_rdata", l2_rdata, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    tick();
    chk("t1_dataok", dataok, 1);
    tick();
    chk("t1_dataok_pulse", dataok, 0);

    // 2: L2 not ready for 5 cycles after rlast
    rdy = 0; req_r = 1; addr_r = 32'h1000_0040;
    tick();
    arready = 1;
    tick();
    arready = 0; req_r = 0;
    rd_beats(32'hB0, 4);
    for (int i = 0; i < 5; i++) begin
      chk("t2_dataok_held", dataok, 0);
      tick();
    end
    rdy = 1;
    #1 chk("t2_dataok_same_cycle", dataok, 0);
    tick();
    chk("t2_dataok", dataok, 1);
    chk("t2_rdata", l2_rdata, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    tick();
    chk("t2_dataok_pulse", dataok, 0);

    // 3: write-back followed by a refill to a different line
    req_w = 1; addr_w = 32'h2000_0000; l2_wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    req_r = 1; addr_r = 32'h3000_0000;
    #1 chk("t3_addrok_w", addrok_w, 1);
    chk("t3_addrok_r", addrok_r, 0);
    tick();
    req_w = 0;
    chk("t3_awvalid", awvalid, 1);
    chk("t3_awaddr", awaddr, 32'h2000_0000);
    chk("t3_awlen", awlen, 3);
    chk("t3_wvalid", wvalid, 1);
    chk("t3_wdata0", wdata, 32'hD0);
    chk("t3_wstrb", wstrb, 4'hF);
    chk("t3_wlast0", wlast, 0);
`ifdef L2AXI_RAW_BYPASS_EN
    chk("t3_arvalid_bypass", arvalid, 1);
`else
    chk("t3_arvalid_blocked", arvalid, 0);
`endif
    awready = 1; wready = 1;
    tick();
    awready = 0;
    chk("t3_aw_done", awvalid, 0);
    chk("t3_wdata1", wdata, 32'hD1);
    tick();
    chk("t3_wdata2", wdata, 32'hD2);
    tick();
    chk("t3_wdata3", wdata, 32'hD3);
    chk("t3_wlast3", wlast, 1);
    tick();
    wready = 0;
    chk("t3_wvalid_off", wvalid, 0);
    chk("t3_bready", bready, 1);
    tick();
`ifndef L2AXI_RAW_BYPASS_EN
    chk("t3_arvalid_resp", arvalid, 0);
`endif
    bvalid = 1;
    tick();
    bvalid = 0;
    chk("t3_bready_off", bready, 0);
`ifndef L2AXI_RAW_BYPASS_EN
    chk("t3_arvalid_post_b", arvalid, 0);
    tick();
`endif
    chk("t3_arvalid", arvalid, 1);
    chk("t3_araddr", araddr, 32'h3000_0000);
    arready = 1;
    tick();
    arready = 0; req_r = 0;
    rd_beats(32'hC0, 4);
    tick();
    chk("t3_dataok", dataok, 1);
    tick();

    // 4: SUC write with AW accepted three cycles after the W beat
    req_w = 1; suc = 1; addr_w = 32'h8000_0004; l2_wstrb = 4'b0011;
    l2_wdata = {96'h0, 32'hCAFE_BABE};
    #1 chk("t4_addrok_w", addrok_w, 1);
    tick();
    req_w = 0; suc = 0;
    chk("t4_awlen", awlen, 0);
    chk("t4_awaddr", awaddr, 32'h8000_0004);
    chk("t4_wlast", wlast, 1);
    chk("t4_wstrb", wstrb, 4'b0011);
    chk("t4_wdata", wdata, 32'hCAFE_BABE);
    wready = 1;
    tick();
    wready = 0;
    chk("t4_wvalid_off", wvalid, 0);
    chk("t4_awvalid_held", awvalid, 1);
    chk("t4_no_resp1", bready, 0);
    tick();
    chk("t4_no_resp2", bready, 0);
    tick();
    awready = 1;
    tick();
    awready = 0;
    chk("t4_resp", bready, 1);
    chk("t4_awvalid_off", awvalid, 0);
    bvalid = 1;
    tick();
    bvalid = 0;
    chk("t4_idle", bready, 0);

    // 5: SUC read, single beat into word 0
    req_r = 1; suc = 1; addr_r = 32'h8000_0008;
    tick();
    chk("t5_araddr", araddr, 32'h8000_0008);
    chk("t5_arlen", arlen, 0);
    arready = 1;
    tick();
    arready = 0; req_r = 0; suc = 0;
    chk("t5_rdata_stable", l2_rdata, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    rd_beats(32'h1234_5678, 1);
    chk("t5_rdata", l2_rdata, {96'h0, 32'h1234_5678});
    tick();
    chk("t5_dataok", dataok, 1);
    tick();

    // 6: reset during beat 2, then a clean read
    req_r = 1; addr_r = 32'h1000_0100;
    tick();
    arready = 1;
    tick();
    arready = 0; req_r = 0;
    rvalid = 1; rdata = 32'hF0; tick();
    rdata = 32'hF1; tick();
    rdata = 32'hF2; rstn = 0;
    tick();
    rvalid = 0; rstn = 1;
    chk("t6_arvalid", arvalid, 0);
    chk("t6_rready", rready, 0);
    chk("t6_dataok", dataok, 0);
    chk("t6_rdata", l2_rdata, 0);
    tick();
    chk("t6_no_dataok", dataok, 0);
    req_r = 1; addr_r = 32'h1000_0208;
    tick();
    chk("t6_araddr", araddr, 32'h1000_0200);
    arready = 1;
    tick();
    arready = 0; req_r = 0;
    rd_beats(32'hE0, 4);
    chk("t6_rdata_new", l2_rdata, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
    tick();
    chk("t6_dataok_new", dataok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2cache_axi_bridge.md
Name: l2cache_axi_bridge

Overview:
Memory-side stage directly downstream of the L2 cache controller FSM. It converts the L2's line-granular request/ack handshake (req_r/req_w, addrOK_r/addrOK_w, dataOK, rdy) into AXI4 burst transactions toward the memory interconnect.
- Cached lines use INCR bursts of 2^offset_width words.
- Strongly-ordered (SUC) accesses use single beats.
- Write-backs are posted through a one-line write buffer so the L2 can start its refill immediately.

Parameters:
offset_width, 2, log2(words per line); line = 2^offset_width 32-bit words (4 by default)
AXI_ID, 4'd1, constant ARID/AWID driven on every transaction

Ports:
clk  in  1  clock; all logic on posedge
rstn  in  1  reset; synchronous, active-low
l2cache_mem_req_r  in  1  read request; held until addrOK_r or dataOK
l2cache_mem_req_w  in  1  write request; held until addrOK_w
l2cache_mem_rdy  in  1  L2 ready to take read data
l2cache_mem_SUC  in  1  strongly-ordered access, single word
l2cache_mem_addr_r  in  32  read address
l2cache_mem_addr_w  in  32  write address
l2cache_mem_wdata  in  32<<offset_width  write line; word 0 in bits [31:0]
l2cache_mem_wstrb  in  4  byte strobe, used only when SUC=1
mem_l2cache_addrOK_r  out  1  read address accepted (pulse)
mem_l2cache_addrOK_w  out  1  write captured into buffer (pulse)
mem_l2cache_dataOK  out  1  read line/word delivered (pulse)
mem_l2cache_rdata  out  32<<offset_width  assembled read line
arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI AR channel
arready  in  1  AXI AR channel
rdata/rlast/rvalid  in  32/1/1  AXI R channel
rready  out  1  AXI R channel
awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI AW channel
awready  in  1  AXI AW channel
wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI W channel
wready  in  1  AXI W channel
bvalid  in  1  AXI B channel
bready  out  1  AXI B channel

Behaviour:
Reset values:
- All valid/ready/OK outputs 0; rdata buffer 0; both FSMs idle.
- Reset mid-burst abandons the transaction; the interconnect is reset by the same rstn.

Fixed AXI fields:
- arsize = awsize = 3'b010; arburst = awburst = INCR.
- Cached: len = 2^offset_width - 1, address aligned to the line (low offset_width+2 bits zeroed).
- SUC: len = 0, full address.

Read FSM: R_IDLE -> R_AR -> R_DATA -> R_DONE.
- R_IDLE: on req_r, when the write-ordering check passes, latch address and SUC, go to R_AR.
- R_AR: arvalid = 1. On arready, pulse addrOK_r for one cycle and go to R_DATA.
- R_DATA: rready = 1. Each beat writes word[beat_cnt]; beat_cnt wraps at the line size. On rvalid & rlast go to R_DONE.
- R_DONE: hold; when rdy = 1, pulse dataOK for one cycle and return to R_IDLE. rdata stays stable until the next read's first beat.
- SUC read: data lands in word 0; other words are zero.

Write FSM: W_IDLE -> W_XFER -> W_RESP.
- W_IDLE: on req_w, capture address, line and strobe; pulse addrOK_w in that same cycle; go to W_XFER. req_w is never acknowledged outside W_IDLE.
- W_XFER: awvalid and wvalid are driven concurrently. aw_done latches on AW handshake. Beats advance on wvalid & wready. wlast on the final beat. wstrb = 4'hF for cached, the latched strobe for SUC.
- W_XFER exits to W_RESP when aw_done and the last W beat are both complete.
- W_RESP: bready = 1; on bvalid return to W_IDLE. BRESP is ignored.

Write ordering (macro off):
- A read leaves R_IDLE only when the write FSM is in W_IDLE. This prevents a refill from overtaking the dirty victim it just evicted.

Simultaneous events:
- req_r and req_w in the same cycle: the write is captured first (addrOK_w). The read then waits under the ordering rule.
- The read and write FSMs are otherwise independent.

Optional Feature:
Macro L2AXI_RAW_BYPASS_EN.
- Defined: a read stalls only when the buffered write line address equals the read line address (addr[31:offset_width+2]). Otherwise AR issues while the write drains.
- Undefined: strict ordering; every read waits for W_IDLE.

Decomposition:
- Shared package l2axi_pkg: burst/size/len constants, read and write state encodings, line-width localparam function of offset_width.
- One sub-module, l2axi_wbuf: the line write buffer plus W-beat sequencer (capture, beat_cnt, wlast generation).

Test Plan:
1. Cached read, addr 0x1000_0014, arready after 2 cycles, 4 beats 0xA0..0xA3 -> araddr 0x1000_0010, arlen 3, one addrOK_r pulse, rdata {A3,A2,A1,A0}, single dataOK pulse after rlast.
2. rdy held low 5 cycles after rlast -> dataOK stays 0, asserts exactly one cycle after rdy rises, rdata unchanged.
3. Write-back line {0xD3..0xD0} to 0x2000_0000, then immediate req_r to 0x3000_0000 -> addrOK_w in the capture cycle. Without macro, arvalid stays low until bvalid. With macro, arvalid rises next cycle.
4. SUC write 0x8000_0004, wstrb 4'b0011, awready delayed 3 cycles after wready -> awlen 0, wlast on the single beat, wstrb 0011, W_RESP entered only after aw_done.
5. SUC read 0x8000_0008, rdata 0x1234_5678 -> arlen 0, word0 = 0x1234_5678, other words 0.
6. rstn low during R_DATA beat 2 -> all valids 0 next cycle, no dataOK, clean new read afterward.
